// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, single outstanding imem request,
// wrong-path squash on branch/jump redirect, and a one-entry output buffer to decode.
module fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_taken,
  input  logic            jump_taken,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready,
  output logic            misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            misaligned_q, misaligned_d;

  logic            redirect_s;
  logic            req_valid_s;
  logic [XLEN-1:0] target_s;
  // Bit 0 of the target is cleared by JALR semantics and never consulted.
  logic            unused_target_bit0;

  assign unused_target_bit0 = redirect_target[0];
  assign redirect_s = branch_taken | jump_taken;
  assign target_s   = {redirect_target[XLEN-1:2], 2'b00};

  // Next-state, request handshake and buffer update.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    misaligned_d = 1'b0;
    req_valid_s  = 1'b0;

    if (if_valid_q && id_ready) begin
      if_valid_d = 1'b0;
    end else begin
      if_valid_d = if_valid_q;
    end

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        // Only fetch when the buffer can take the result; never fetch on a redirect.
        req_valid_s = (!if_valid_q || id_ready) && !redirect_s;
        if (req_valid_s && imem_req_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(3'd4);
          state_d  = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (imem_resp_valid && !redirect_s) begin
          if_instr_d = imem_resp_data;
          if_pc_d    = req_pc_q;
          if_valid_d = 1'b1;
          state_d    = REQ;
        end else begin
          state_d = WAIT;
        end
      end
      DROP: begin
        if (imem_resp_valid) begin
          state_d = REQ;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Redirect wins over drain, load and sequential pc advance.
    if (redirect_s && (state_q != IDLE)) begin
      pc_d         = target_s;
      if_valid_d   = 1'b0;
      misaligned_d = redirect_target[1];
      if (state_q == WAIT || state_q == DROP) begin
        state_d = imem_resp_valid ? REQ : DROP;
      end else begin
        state_d = REQ;
      end
    end else begin
      misaligned_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = pc_q;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;
  assign misaligned     = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, reset corner sequence, and a
// randomized run against a transaction-level scoreboard of the fetch stream.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken, jump_taken;
  logic [31:0] redirect_target;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        id_ready;
  logic        misaligned;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .branch_taken(branch_taken), .jump_taken(jump_taken),
    .redirect_target(redirect_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          bt, jt;
    logic [31:0] tgt;
    bit          rr, rsv;
    logic [31:0] rsd;
    bit          idr;
    bit          erv;
    logic [31:0] eaddr;
    bit          eiv;
    logic [31:0] epc, einstr;
    bit          emis;
  } vec_t;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic vec_t mk(bit bt, bit jt, logic [31:0] tgt, bit rr, bit rsv,
                              logic [31:0] rsd, bit idr, bit erv, logic [31:0] eaddr,
                              bit eiv, logic [31:0] epc, logic [31:0] ein, bit emis);
    vec_t v;
    v.bt = bt; v.jt = jt; v.tgt = tgt; v.rr = rr; v.rsv = rsv; v.rsd = rsd;
    v.idr = idr; v.erv = erv; v.eaddr = eaddr; v.eiv = eiv; v.epc = epc;
    v.einstr = ein; v.emis = emis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    branch_taken = 1'b0; jump_taken = 1'b0; redirect_target = 32'h0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    id_ready = 1'b1;
  endtask

  vec_t vecs[$];

  // Scoreboard state for the random run
  logic [31:0] mpc;
  bit          mem_busy, squashed, exp_mis;
  logic [31:0] mem_addr;
  int          mem_wait;
  int          delivered;
  logic [31:0] eq_pc[$];
  logic [31:0] eq_in[$];

  initial begin
    // Rows start in IDLE, the first cycle after reset release.
    vecs.push_back(mk(0,0,32'h0,   0,0,32'h0,          1, 0,32'h0,   0,32'h0,  32'h0,          0));
    vecs.push_back(mk(0,0,32'h0,   1,0,32'h0,          1, 1,32'h0,   0,32'h0,  32'h0,          0));
    vecs.push_back(mk(0,0,32'h0,   0,1,instr_of(32'h0),1, 0,32'h0,   0,32'h0,  32'h0,          0));
    vecs.push_back(mk(0,0,32'h0,   1,0,32'h0,          0, 0,32'h0,   1,32'h0,  instr_of(32'h0),0));
    vecs.push_back(mk(0,0,32'h0,   1,0,32'h0,          0, 0,32'h0,   1,32'h0,  instr_of(32'h0),0));
    vecs.push_back(mk(0,0,32'h0,   1,0,32'h0,          1, 1,32'h4,   1,32'h0,  instr_of(32'h0),0));
    vecs.push_back(mk(0,0,32'h0,   0,1,instr_of(32'h4),1, 0,32'h0,   0,32'h0,  32'h0,          0));
    vecs.push_back(mk(0,0,32'h0,   1,0,32'h0,          1, 1,32'h8,   1,32'h4,  instr_of(32'h4),0));
    vecs.push_back(mk(1,0,32'h100, 0,0,32'h0,          1, 0,32'h0,   0,32'h0,  32'h0,          0));
    vecs.push_back(mk(0,0,32'h0,   0,1,32'hDEAD_BEEF,  1, 0,32'h0,   0,32'h0,  32'h0,          0));
    vecs.push_back(mk(0,0,32'h0,   1,0,32'h0,          1, 1,32'h100, 0,32'h0,  32'h0,          0));
    vecs.push_back(mk(0,0,32'h0,   0,1,instr_of(32'h100),1,0,32'h0,  0,32'h0,  32'h0,          0));
    vecs.push_back(mk(0,0,32'h0,   1,0,32'h0,          1, 1,32'h104, 1,32'h100,instr_of(32'h100),0));
    vecs.push_back(mk(0,1,32'h200, 0,1,instr_of(32'h104),1,0,32'h0,  0,32'h0,  32'h0,          0));
    vecs.push_back(mk(0,0,32'h0,   1,0,32'h0,          1, 1,32'h200, 0,32'h0,  32'h0,          0));
    vecs.push_back(mk(0,0,32'h0,   0,1,instr_of(32'h200),1,0,32'h0,  0,32'h0,  32'h0,          0));
    vecs.push_back(mk(1,0,32'h106, 1,0,32'h0,          0, 0,32'h0,   1,32'h200,instr_of(32'h200),0));
    vecs.push_back(mk(0,0,32'h0,   1,0,32'h0,          1, 1,32'h104, 0,32'h0,  32'h0,          1));
    vecs.push_back(mk(0,0,32'h0,   0,0,32'h0,          1, 0,32'h0,   0,32'h0,  32'h0,          0));
    vecs.push_back(mk(0,0,32'h0,   0,1,instr_of(32'h104),1,0,32'h0,  0,32'h0,  32'h0,          0));
    vecs.push_back(mk(0,0,32'h0,   0,0,32'h0,          1, 1,32'h108, 1,32'h104,instr_of(32'h104),0));
    vecs.push_back(mk(0,0,32'h0,   1,0,32'h0,          1, 1,32'h108, 0,32'h0,  32'h0,          0));
    vecs.push_back(mk(0,0,32'h0,   0,1,instr_of(32'h108),1,0,32'h0,  0,32'h0,  32'h0,          0));
    vecs.push_back(mk(0,1,32'h3C,  0,0,32'h0,          1, 0,32'h0,   1,32'h108,instr_of(32'h108),0));
    vecs.push_back(mk(0,0,32'h0,   1,0,32'h0,          1, 1,32'h3C,  0,32'h0,  32'h0,          0));

    // Reset state
    drive_idle();
    rst = 1'b1;
    #3;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_if_valid",  {31'b0, if_valid}, 32'h0);
    chk("rst_if_pc",     if_pc, 32'h0);
    chk("rst_if_instr",  if_instr, 32'h0);
    chk("rst_misaligned",{31'b0, misaligned}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cycle table
    for (int i = 0; i < vecs.size(); i++) begin
      branch_taken = vecs[i].bt; jump_taken = vecs[i].jt; redirect_target = vecs[i].tgt;
      imem_req_ready = vecs[i].rr; imem_resp_valid = vecs[i].rsv;
      imem_resp_data = vecs[i].rsd; id_ready = vecs[i].idr;
      #3;
      chk($sformatf("v%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].erv});
      if (vecs[i].erv) chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].eaddr);
      chk($sformatf("v%0d_if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].eiv});
      if (vecs[i].eiv) begin
        chk($sformatf("v%0d_if_pc", i), if_pc, vecs[i].epc);
        chk($sformatf("v%0d_if_instr", i), if_instr, vecs[i].einstr);
      end
      chk($sformatf("v%0d_misaligned", i), {31'b0, misaligned}, {31'b0, vecs[i].emis});
      @(posedge clk); #1;
    end

    // Async reset while WAIT with pc=0x40, then a late response
    drive_idle();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_BAD0;
    rst = 1'b1;
    #1;
    chk("arst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("arst_if_valid",  {31'b0, if_valid}, 32'h0);
    chk("arst_if_pc",     if_pc, 32'h0);
    chk("arst_if_instr",  if_instr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #3;
    chk("post_rst_idle_req", {31'b0, imem_req_valid}, 32'h0);
    @(posedge clk); #1;
    #3;
    chk("post_rst_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("post_rst_req_addr",  imem_req_addr, 32'h0);
    chk("post_rst_if_valid",  {31'b0, if_valid}, 32'h0);
    @(posedge clk); #1;
    imem_resp_valid = 1'b0; imem_req_ready = 1'b1;
    #3;
    chk("late_resp_if_valid", {31'b0, if_valid}, 32'h0);
    chk("late_resp_req_addr", imem_req_addr, 32'h0);

    // Randomized run against the fetch-stream scoreboard
    @(posedge clk); #1;
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mpc = 32'h0; mem_busy = 0; squashed = 0; exp_mis = 0; mem_wait = 0; delivered = 0;
    mem_addr = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      branch_taken = (cyc >= 2) && ($urandom_range(0, 11) == 0);
      jump_taken   = (cyc >= 2) && ($urandom_range(0, 19) == 0);
      redirect_target = $urandom;
      if ($urandom_range(0, 5) == 0) redirect_target = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
      id_ready       = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 2) != 0);
      if (mem_busy && mem_wait == 0) begin
        imem_resp_valid = 1'b1; imem_resp_data = instr_of(mem_addr);
      end else begin
        imem_resp_valid = 1'b0; imem_resp_data = $urandom;
      end
      #3;
      chk("rnd_if_valid", {31'b0, if_valid}, {31'b0, (eq_pc.size() != 0)});
      if (if_valid && eq_pc.size() != 0) begin
        chk("rnd_if_pc", if_pc, eq_pc[0]);
        chk("rnd_if_instr", if_instr, eq_in[0]);
      end
      chk("rnd_misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
      if (imem_req_valid) begin
        chk("rnd_req_during_redirect", {31'b0, branch_taken | jump_taken}, 32'h0);
        chk("rnd_req_while_busy", {31'b0, mem_busy}, 32'h0);
        chk("rnd_req_buffer_full", {31'b0, if_valid & ~id_ready}, 32'h0);
      end
      if (branch_taken || jump_taken) begin
        eq_pc.delete(); eq_in.delete();
        mpc = redirect_target & 32'hFFFF_FFFC;
        if (mem_busy) squashed = 1;
        exp_mis = redirect_target[1];
      end else begin
        exp_mis = 0;
        if (if_valid && id_ready && eq_pc.size() != 0) begin
          void'(eq_pc.pop_front()); void'(eq_in.pop_front());
          delivered++;
        end
        if (imem_resp_valid && !squashed) begin
          eq_pc.push_back(mem_addr); eq_in.push_back(instr_of(mem_addr));
        end
      end
      if (imem_resp_valid) mem_busy = 0;
      else if (mem_busy) mem_wait--;
      if (imem_req_valid && imem_req_ready) begin
        chk("rnd_req_addr", imem_req_addr, mpc);
        mpc = mpc + 32'd4;
        mem_busy = 1; mem_addr = imem_req_addr; squashed = 0;
        mem_wait = $urandom_range(0, 2);
      end
      @(posedge clk); #1;
    end
    chk("rnd_progress", {31'b0, (delivered > 100)}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that consumes the branch unit's branch_taken decision (plus unconditional jumps) and the EX-stage target address. It holds the program counter and issues one instruction-memory request at a time. It squashes wrong-path fetches on redirect and hands fetched instructions to decode through a single-entry valid/ready output buffer.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, address and instruction width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
branch_taken  input  1  from branch unit: conditional branch resolved taken this cycle
jump_taken  input  1  from control unit: JAL/JALR in EX this cycle
redirect_target  input  XLEN  target address, valid when branch_taken or jump_taken
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  XLEN  fetch address
imem_resp_valid  input  1  instruction data valid this cycle
imem_resp_data  input  XLEN  instruction word
if_valid  output  1  output buffer holds an instruction
if_instr  output  XLEN  buffered instruction
if_pc  output  XLEN  address of buffered instruction
id_ready  input  1  decode consumes buffer this cycle when if_valid=1 (hazard stall folded in)
misaligned  output  1  one-cycle pulse: redirect target had bit[1]=1

Behaviour:
- redirect = branch_taken | jump_taken. Effective target = {redirect_target[XLEN-1:2], 2'b00}. misaligned is registered, set the cycle after a redirect with redirect_target[1]=1; bit[0] is silently ignored (JALR clear).
- Registers: pc (next fetch address), req_pc (address of in-flight request), output buffer {if_valid, if_instr, if_pc}, state.
- States: IDLE, REQ, WAIT, DROP.
- Reset (async): state=IDLE, pc=RESET_PC, req_pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, misaligned=0. imem_req_valid=0 in IDLE.
- IDLE -> REQ unconditionally on the first clock after reset release.
- REQ: imem_req_valid = (!if_valid | id_ready) & !redirect; imem_req_addr = pc. On acceptance (valid & ready): req_pc<=pc, pc<=pc+4 (mod 2^XLEN wrap), -> WAIT.
- WAIT: imem_req_valid=0. On imem_resp_valid: if_instr<=imem_resp_data, if_pc<=req_pc, if_valid<=1, -> REQ. The buffer is always free here because a request is only issued when the buffer is empty or draining.
- DROP: awaiting the response of a squashed request. On imem_resp_valid: discard data, -> REQ.
- Buffer drain: if_valid & id_ready & no load this cycle -> if_valid<=0.
- Redirect (highest priority, any state except IDLE):
  - pc<=effective target; if_valid<=0 (flush overrides id_ready and any same-cycle load).
  - REQ: no request is issued this cycle; stay REQ.
  - WAIT without response -> DROP.
  - WAIT with same-cycle response -> response discarded, -> REQ.
  - DROP without response -> stay DROP.
  - DROP with same-cycle response -> REQ.
- Unaccepted requests carry no address-stability guarantee; the memory samples only on acceptance.
- Latency: request accepted at cycle N, response at cycle M≥N+1, if_valid=1 at M+1. Next request can be accepted at M+1, so peak throughput is one instruction per 2 cycles with a 1-cycle memory.
- Reset mid-operation: all state is cleared immediately. Any late response is ignored because state=IDLE/REQ.

Test Plan:
- Reset release, 1-cycle memory, id_ready=1 -> requests at 0x0, 0x4, 0x8 on alternate cycles; if_pc sequence 0x0, 0x4, 0x8 with matching if_instr.
- id_ready=0 after first instruction -> if_valid held with if_pc=0x0; no new request until id_ready=1; then next request addr=0x4.
- branch_taken=1, target=0x100, in WAIT -> if_valid=0, state DROP; stale response discarded; next request addr=0x100, if_pc=0x100.
- jump_taken with response in the same cycle, target=0x200 -> response dropped, no DROP state; next request addr=0x200.
- Redirect to 0x00000106 -> misaligned pulses one cycle; fetch addr=0x104.
- Async reset asserted in WAIT with pc=0x40 -> outputs cleared immediately; after release, first request addr=RESET_PC; late response does not set if_valid.
